// File: rtl/gf180mcu_osu_sc_clkdiv_pkg.sv
// gf180mcu_osu_sc_clkdiv_pkg: shared state type, minimum ratio and DIV clamp for the clock divider.
package gf180mcu_osu_sc_clkdiv_pkg;

    typedef enum logic {STOP, RUN} state_t;

    localparam logic [31:0] MIN_DIV = 32'd2;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_odd50.sv
// gf180mcu_osu_sc_gp12t3v3__clkdiv_odd50: negedge duty-stretch flop that delays the fall of Y by half a CLK for odd ratios.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_odd50 (
    input  logic clk,
    input  logic rst_n,
    input  logic y_in,
    input  logic odd,
    output logic y_out
);

    logic y_neg;

    always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) y_neg <= 1'b0;
        else        y_neg <= y_in;

    // y_neg is still low when y_in rises, so only the falling edge moves
    assign y_out = y_in | (odd & y_neg);

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv.sv
// gf180mcu_osu_sc_gp12t3v3__clkdiv: glitch-free programmable integer clock divider with safe ratio reload.
// Define GF180MCU_OSU_SC_CLKDIV_ODD50_EN for 50% duty cycle on odd ratios.
module gf180mcu_osu_sc_gp12t3v3__clkdiv
    import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEF_DIV = 4
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         EN,
    input  logic [W-1:0] DIV,
    input  logic         LD,
    output logic         BUSY,
    output logic         Y,
    output logic         TICK
);

    state_t       state, state_d;
    logic [W-1:0] cnt, cnt_d, n, n_d, pend, pend_d;
    logic         y_r, y_d, tick_r, tick_d, busy_r, busy_d, bnd;

    always_comb begin
        bnd     = (state == RUN) && (cnt == n - W'(1));
        state_d = state;
        cnt_d   = cnt;
        y_d     = y_r;
        tick_d  = 1'b0;
        n_d     = n;
        pend_d  = pend;
        busy_d  = busy_r;
        if (state == STOP || bnd) begin
            if (busy_r) begin
                n_d    = pend;
                busy_d = 1'b0;
            end
            cnt_d = '0;
            if (EN) begin
                state_d = RUN;
                y_d     = 1'b1;
                tick_d  = 1'b1;
            end else begin
                state_d = STOP;
                y_d     = 1'b0;
            end
        end else begin
            cnt_d = cnt + W'(1);
            if (cnt_d == (n >> 1)) y_d = 1'b0;
        end
        // a strobe on the boundary edge lands after the apply above, so it waits a period
        if (LD) begin
            pend_d = W'(clamp_div(32'(DIV)));
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN)
        if (!RN) begin
            state  <= STOP;
            cnt    <= '0;
            y_r    <= 1'b0;
            tick_r <= 1'b0;
            n      <= W'(DEF_DIV);
            pend   <= W'(DEF_DIV);
            busy_r <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            y_r    <= y_d;
            tick_r <= tick_d;
            n      <= n_d;
            pend   <= pend_d;
            busy_r <= busy_d;
        end

    assign BUSY = busy_r;
    assign TICK = tick_r;

`ifdef GF180MCU_OSU_SC_CLKDIV_ODD50_EN
    gf180mcu_osu_sc_gp12t3v3__clkdiv_odd50 u_odd50 (
        .clk  (CLK),
        .rst_n(RN),
        .y_in (y_r),
        .odd  (n[0]),
        .y_out(Y)
    );
`else
    assign Y = y_r;
`endif

endmodule
